soc_periph_req_scheduler: RTL and testbench

- Round-robin scheduler sharing the single SoC peripheral access port between NUM_REQ requesters (debug module, CVA6 cores, cluster, uDMA tx/rx).
- Accepts one request at a time, decodes its address against the fixed SoC memory map into a peripheral index, drives the shared peripheral port, and returns the response to the winner.
- Misses in the map are answered locally with an error response; the peripheral port is not touched.

---
 rtl/soc_periph_req_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_soc_periph_req_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_periph_req_scheduler.sv
// soc_periph_req_scheduler
// Round-robin scheduler that shares the single SoC peripheral access port
// between NUM_REQ requesters. One transaction is in flight at a time: the
// winner's address is decoded against the fixed SoC memory map, hits are
// issued on the peripheral port, and misses are answered locally with an
// error response without touching the peripheral port.
//
// Optional build macro: SOC_PERIPH_SCHED_TIMEOUT_EN
//   When defined, a response watchdog turns a transaction that has spent
//   TIMEOUT_CYCLES cycles in ISSUE/WAIT_RSP into an error response.
//   When undefined, no counter exists and the scheduler waits indefinitely.
module soc_periph_req_scheduler #(
  parameter int NUM_REQ        = 6,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]             req_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic                           slv_req_o,
  output logic [3:0]                     slv_sel_o,
  output logic [31:0]                    slv_addr_o,
  output logic                           slv_we_o,
  output logic [DATA_WIDTH-1:0]          slv_wdata_o,
  input  logic                           slv_gnt_i,
  input  logic                           slv_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]          slv_rdata_i,
  input  logic                           slv_err_i,
  output logic                           busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    ERR_RSP  = 2'd3
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rrPtr;
  logic [PTR_W-1:0]      r_winner;
  logic                  r_slvReq;
  logic [3:0]            r_slvSel;
  logic [31:0]           r_slvAddr;
  logic                  r_slvWe;
  logic [DATA_WIDTH-1:0] r_slvWdata;

  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;
  logic [ADDR_WIDTH-1:0] w_winAddr;
  logic                  w_winWe;
  logic [DATA_WIDTH-1:0] w_winWdata;
  logic                  w_hit;
  logic [3:0]            w_sel;
  logic                  w_accept;
  logic                  w_timeout;
  logic [PTR_W-1:0]      w_nextPtr;

  // First valid requester at or above ptr, wrapping around. Scanning from
  // the far end down lets the nearest candidate overwrite the others.
  function automatic logic [PTR_W:0] findWinner(input logic [NUM_REQ-1:0] valid,
                                                input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] result;
    int             idx;
    result = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[idx]) result = {1'b1, PTR_W'(idx)};
    end
    return result;
  endfunction

  // Half-open range test; the end address is formed 33 bits wide so a
  // region touching the top of the 32-bit space cannot wrap.
  function automatic logic inRange(input logic [31:0] a,
                                   input logic [31:0] base,
                                   input logic [31:0] len);
    logic [32:0] endAddr;
    endAddr = {1'b0, base} + {1'b0, len};
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < endAddr);
  endfunction

  // SoC memory map lookup: returns {hit, peripheral index}.
  function automatic logic [4:0] decodeAddr(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] a;
    logic [4:0]  r;
    a = addr[31:0];
    r = '0;
    if ((addr >> 32) == '0) begin
      if      (inRange(a, 32'h0000_0000, 32'h0000_1000)) r = {1'b1, 4'd0};
      else if (inRange(a, 32'h0001_0000, 32'h0001_0000)) r = {1'b1, 4'd1};
      else if (inRange(a, 32'h0200_0000, 32'h000C_0000)) r = {1'b1, 4'd2};
      else if (inRange(a, 32'h0C00_0000, 32'h03FF_FFFF)) r = {1'b1, 4'd3};
      else if (inRange(a, 32'h1000_0000, 32'h0040_0000)) r = {1'b1, 4'd4};
      else if (inRange(a, 32'h1C00_0000, 32'h0001_0000)) r = {1'b1, 4'd5};
      else if (inRange(a, 32'h1A10_0000, 32'h0012_3000)) r = {1'b1, 4'd6};
      else if (inRange(a, 32'h1800_0000, 32'h0000_1000)) r = {1'b1, 4'd7};
      else if (inRange(a, 32'h2000_0000, 32'h0080_0000)) r = {1'b1, 4'd8};
      else if (inRange(a, 32'h3000_0000, 32'h0001_0000)) r = {1'b1, 4'd9};
      else if (inRange(a, 32'h4000_0000, 32'h0000_1000)) r = {1'b1, 4'd10};
      else if (inRange(a, 32'h1040_0000, 32'h0010_0000)) r = {1'b1, 4'd11};
      else if (inRange(a, 32'h8000_0000, 32'h2000_0000)) r = {1'b1, 4'd12};
    end
    return r;
  endfunction

  assign {w_found, w_winner} = findWinner(req_valid_i, r_rrPtr);
  assign w_winAddr  = req_addr_i[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_winWe    = req_we_i[w_winner];
  assign w_winWdata = req_wdata_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
  assign {w_hit, w_sel} = decodeAddr(w_winAddr);
  assign w_accept   = (r_state == IDLE) && w_found && !rst_i;
  assign w_nextPtr  = (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

`ifdef SOC_PERIPH_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMR_W-1:0] r_timer;

  // Watchdog: cleared when a hit is accepted, counts every ISSUE/WAIT_RSP cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (r_state == IDLE) begin
      r_timer <= '0;
    end else if (r_state == ISSUE || r_state == WAIT_RSP) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_state == ISSUE || r_state == WAIT_RSP) &&
                     (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Main FSM: arbitration, request latching, peripheral handshake, rr pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_winner   <= '0;
      r_slvReq   <= 1'b0;
      r_slvSel   <= '0;
      r_slvAddr  <= '0;
      r_slvWe    <= 1'b0;
      r_slvWdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_winner <= w_winner;
            if (w_hit) begin
              r_slvSel   <= w_sel;
              r_slvAddr  <= w_winAddr[31:0];
              r_slvWe    <= w_winWe;
              r_slvWdata <= w_winWdata;
              r_slvReq   <= 1'b1;
              r_state    <= ISSUE;
            end else begin
              r_state <= ERR_RSP;
            end
          end
        end
        ISSUE: begin
          if (w_timeout) begin
            r_slvReq <= 1'b0;
            r_state  <= ERR_RSP;
          end else if (slv_gnt_i) begin
            r_slvReq <= 1'b0;
            r_state  <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (slv_rsp_valid_i) begin
            r_rrPtr <= w_nextPtr;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= ERR_RSP;
          end
        end
        ERR_RSP: begin
          r_rrPtr <= w_nextPtr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One-hot acceptance pulse to the current winner while idle.
  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_winner] = 1'b1;
  end

  // Response path: peripheral response passes straight through in WAIT_RSP,
  // map misses and watchdog expiries answer from ERR_RSP with zero data.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (!rst_i) begin
      if (r_state == WAIT_RSP && slv_rsp_valid_i) begin
        rsp_valid_o[r_winner] = 1'b1;
        rsp_rdata_o           = slv_rdata_i;
        rsp_err_o             = slv_err_i;
      end else if (r_state == ERR_RSP) begin
        rsp_valid_o[r_winner] = 1'b1;
        rsp_err_o             = 1'b1;
      end
    end
  end

  assign slv_req_o   = r_slvReq;
  assign slv_sel_o   = r_slvSel;
  assign slv_addr_o  = r_slvAddr;
  assign slv_we_o    = r_slvWe;
  assign slv_wdata_o = r_slvWdata;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_soc_periph_req_scheduler.sv
// Testbench for soc_periph_req_scheduler: a table of per-cycle vectors with
// hand-computed expectations, plus hand-written stall/reset sequences and,
// when SOC_PERIPH_SCHED_TIMEOUT_EN is defined, a watchdog sequence.
module tb_soc_periph_req_scheduler;

  localparam int NUM_REQ = 6;
  localparam int AW      = 64;
  localparam int DW      = 64;
`ifdef SOC_PERIPH_SCHED_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     reqValid;
  logic [NUM_REQ-1:0]     reqReady;
  logic [NUM_REQ*AW-1:0]  reqAddr;
  logic [NUM_REQ-1:0]     reqWe;
  logic [NUM_REQ*DW-1:0]  reqWdata;
  logic [NUM_REQ-1:0]     rspValid;
  logic [DW-1:0]          rspRdata;
  logic                   rspErr;
  logic                   slvReq;
  logic [3:0]             slvSel;
  logic [31:0]            slvAddr;
  logic                   slvWe;
  logic [DW-1:0]          slvWdata;
  logic                   slvGnt;
  logic                   slvRspValid;
  logic [DW-1:0]          slvRdata;
  logic                   slvErr;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  soc_periph_req_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
    .req_we_i(reqWe), .req_wdata_i(reqWdata),
    .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr),
    .slv_req_o(slvReq), .slv_sel_o(slvSel), .slv_addr_o(slvAddr),
    .slv_we_o(slvWe), .slv_wdata_o(slvWdata),
    .slv_gnt_i(slvGnt), .slv_rsp_valid_i(slvRspValid), .slv_rdata_i(slvRdata),
    .slv_err_i(slvErr), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  valid;
    logic [63:0] addr;
    logic [5:0]  we;
    logic        gnt;
    logic        rspV;
    logic [63:0] rdata;
    logic        sErr;
  } in_t;

  typedef struct {
    logic [5:0]  rdy;
    logic [5:0]  rspV;
    logic [63:0] rspD;
    logic        rspE;
    logic        sReq;
    logic [3:0]  sel;
    logic [31:0] sAddr;
    logic        sWe;
    logic [63:0] sWd;
    logic        busy;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  vec_t vecs[$];

  // Write data of requester k is k repeated in every byte.
  function automatic logic [63:0] wdPat(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k);
  endfunction

  function automatic in_t mkIn(input logic r, input logic [5:0] v, input logic [63:0] a,
                               input logic [5:0] we, input logic g, input logic rv,
                               input logic [63:0] rd, input logic se);
    in_t t;
    t.rst = r; t.valid = v; t.addr = a; t.we = we;
    t.gnt = g; t.rspV = rv; t.rdata = rd; t.sErr = se;
    return t;
  endfunction

  function automatic exp_t mkExp(input logic [5:0] rdy, input logic [5:0] rv,
                                 input logic [63:0] rd, input logic re, input logic sr,
                                 input logic [3:0] sel, input logic [31:0] sa,
                                 input logic swe, input logic [63:0] swd, input logic b);
    exp_t e;
    e.rdy = rdy; e.rspV = rv; e.rspD = rd; e.rspE = re; e.sReq = sr;
    e.sel = sel; e.sAddr = sa; e.sWe = swe; e.sWd = swd; e.busy = b;
    return e;
  endfunction

  task automatic addVec(input in_t i, input exp_t e);
    vec_t v;
    v.in = i;
    v.ex = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t i);
    rst         = i.rst;
    reqValid    = i.valid;
    reqWe       = i.we;
    slvGnt      = i.gnt;
    slvRspValid = i.rspV;
    slvRdata    = i.rdata;
    slvErr      = i.sErr;
    for (int k = 0; k < NUM_REQ; k++) begin
      reqAddr[k*AW +: AW]  = i.addr;
      reqWdata[k*DW +: DW] = wdPat(k);
    end
  endtask

  task automatic chk(input string tag, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", tag, name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    chk(tag, "req_ready", 64'(reqReady), 64'(e.rdy));
    chk(tag, "rsp_valid", 64'(rspValid), 64'(e.rspV));
    chk(tag, "rsp_rdata", rspRdata, e.rspD);
    chk(tag, "rsp_err", 64'(rspErr), 64'(e.rspE));
    chk(tag, "slv_req", 64'(slvReq), 64'(e.sReq));
    chk(tag, "slv_sel", 64'(slvSel), 64'(e.sel));
    chk(tag, "slv_addr", 64'(slvAddr), 64'(e.sAddr));
    chk(tag, "slv_we", 64'(slvWe), 64'(e.sWe));
    chk(tag, "slv_wdata", slvWdata, e.sWd);
    chk(tag, "busy", 64'(busy), 64'(e.busy));
  endtask

  // One clock: drive just after the rising edge, compare on the falling edge.
  task automatic stepAndCheck(input in_t i, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    applyStimulus(i);
    @(negedge clk);
    checkOutput(e, tag);
  endtask

  localparam logic [63:0] W2 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] W3 = 64'h0303_0303_0303_0303;
  localparam logic [63:0] W4 = 64'h0404_0404_0404_0404;
  localparam logic [63:0] W5 = 64'h0505_0505_0505_0505;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin : main
    in_t  ti;
    exp_t te;
    int   n;

    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    // Reset state
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Req 2 reads UART, same-cycle gnt, response next cycle
    addVec(mkIn(0, 6'b000100, 64'h4000_0000, 0, 0, 0, 0, 0), mkExp(6'b000100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 1, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 10, 32'h4000_0000, 0, W2, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 1, 64'hDEAD, 0), mkExp(0, 6'b000100, 64'hDEAD, 0, 0, 10, 32'h4000_0000, 0, W2, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 10, 32'h4000_0000, 0, W2, 0));
    // Reset cycle: combinational outputs silent, registers still hold
    addVec(mkIn(1, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 10, 32'h4000_0000, 0, W2, 0));
    // Requesters 0,3,5 writing L2SPM continuously; gnt and rsp held high
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 0, 0, 0, 1, 5, 32'h1C00_0000, 1, 0, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 6'b000001, 64'h1234, 0, 0, 5, 32'h1C00_0000, 1, 0, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(6'b001000, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, 0, 0));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 0, 0, 0, 1, 5, 32'h1C00_0000, 1, W3, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 6'b001000, 64'h1234, 0, 0, 5, 32'h1C00_0000, 1, W3, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(6'b100000, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, W3, 0));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 0, 0, 0, 1, 5, 32'h1C00_0000, 1, W5, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 1), mkExp(0, 6'b100000, 64'h1234, 1, 0, 5, 32'h1C00_0000, 1, W5, 1));
    addVec(mkIn(0, 6'b101001, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(6'b000001, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, W5, 0));
    addVec(mkIn(0, 0, 64'h1C00_0000, 6'b101001, 1, 1, 64'h1234, 0), mkExp(0, 0, 0, 0, 1, 5, 32'h1C00_0000, 1, 0, 1));
    addVec(mkIn(0, 0, 64'h1C00_0000, 6'b101001, 0, 1, 64'h1234, 0), mkExp(0, 6'b000001, 64'h1234, 0, 0, 5, 32'h1C00_0000, 1, 0, 1));
    // Req 1 misses: unmapped hole, then upper address bits set
    addVec(mkIn(0, 6'b000010, 64'h5000_0000, 0, 0, 0, 0, 0), mkExp(6'b000010, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 1, 64'hFFFF, 1), mkExp(0, 6'b000010, 0, 1, 0, 5, 32'h1C00_0000, 1, 0, 1));
    addVec(mkIn(0, 6'b000010, 64'h1_0000_0000, 0, 0, 0, 0, 0), mkExp(6'b000010, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 6'b000010, 0, 1, 0, 5, 32'h1C00_0000, 1, 0, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, 0, 0));
    // Boundary decode with req 4: HyperRAM last byte / one past
    addVec(mkIn(0, 6'b010000, 64'h9FFF_FFFF, 0, 0, 0, 0, 0), mkExp(6'b010000, 0, 0, 0, 0, 5, 32'h1C00_0000, 1, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 1, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 12, 32'h9FFF_FFFF, 0, W4, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 1, 64'hBEEF, 0), mkExp(0, 6'b010000, 64'hBEEF, 0, 0, 12, 32'h9FFF_FFFF, 0, W4, 1));
    addVec(mkIn(0, 6'b010000, 64'hA000_0000, 0, 0, 0, 0, 0), mkExp(6'b010000, 0, 0, 0, 0, 12, 32'h9FFF_FFFF, 0, W4, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 6'b010000, 0, 1, 0, 12, 32'h9FFF_FFFF, 0, W4, 1));
    // APB last byte / one past
    addVec(mkIn(0, 6'b010000, 64'h1A22_2FFF, 0, 0, 0, 0, 0), mkExp(6'b010000, 0, 0, 0, 0, 12, 32'h9FFF_FFFF, 0, W4, 0));
    addVec(mkIn(0, 0, 0, 0, 1, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 6, 32'h1A22_2FFF, 0, W4, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 1, 64'h6, 0), mkExp(0, 6'b010000, 64'h6, 0, 0, 6, 32'h1A22_2FFF, 0, W4, 1));
    addVec(mkIn(0, 6'b010000, 64'h1A22_3000, 0, 0, 0, 0, 0), mkExp(6'b010000, 0, 0, 0, 0, 6, 32'h1A22_2FFF, 0, W4, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 6'b010000, 0, 1, 0, 6, 32'h1A22_2FFF, 0, W4, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 6, 32'h1A22_2FFF, 0, W4, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      stepAndCheck(vecs[i].in, vecs[i].ex, $sformatf("row%0d", i));
    end

    // Stall: req 5 writes Cluster, gnt low for 5 cycles, then completes.
    stepAndCheck(mkIn(0, 6'b100000, 64'h1000_0000, 6'b100000, 0, 0, 0, 0),
                 mkExp(6'b100000, 0, 0, 0, 0, 6, 32'h1A22_2FFF, 0, W4, 0), "stall_acc");
    for (int c = 1; c <= 5; c++) begin
      stepAndCheck(mkIn(0, 0, 64'h1000_0000, 6'b100000, 0, 0, 0, 0),
                   mkExp(0, 0, 0, 0, 1, 4, 32'h1000_0000, 1, W5, 1), $sformatf("stall%0d", c));
    end
    stepAndCheck(mkIn(0, 0, 0, 0, 1, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 4, 32'h1000_0000, 1, W5, 1), "stall_gnt");
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 1, 64'h77, 0), mkExp(0, 6'b100000, 64'h77, 0, 0, 4, 32'h1000_0000, 1, W5, 1), "stall_rsp");

    // Reset mid-transaction: req 1 reads Debug, rst in cycle 3, pending rsp dropped.
    stepAndCheck(mkIn(0, 6'b000010, 64'h0000_0800, 0, 0, 0, 0, 0),
                 mkExp(6'b000010, 0, 0, 0, 0, 4, 32'h1000_0000, 1, W5, 0), "rst_acc");
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 0, 32'h0000_0800, 0, 64'h0101_0101_0101_0101, 1), "rst_c1");
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 0, 0, 0), mkExp(0, 0, 0, 0, 1, 0, 32'h0000_0800, 0, 64'h0101_0101_0101_0101, 1), "rst_c2");
    stepAndCheck(mkIn(1, 0, 0, 0, 0, 1, 64'h55, 0), mkExp(0, 0, 0, 0, 1, 0, 32'h0000_0800, 0, 64'h0101_0101_0101_0101, 1), "rst_c3");
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 1, 64'h55, 0), mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_c4");

`ifdef SOC_PERIPH_SCHED_TIMEOUT_EN
    // Watchdog: req 0 to UART, gnt once, no response ever arrives.
    stepAndCheck(mkIn(0, 6'b000001, 64'h4000_0000, 0, 0, 0, 0, 0),
                 mkExp(6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to_acc");
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      applyStimulus(mkIn(0, 0, 0, 0, (n == 0), 0, 0, 0));
      @(negedge clk);
      if (rspValid != 0) break;
      n++;
    end
    chk("timeout", "busy_cycles", 64'(n), 64'(16));
    chk("timeout", "rsp_valid", 64'(rspValid), 64'(6'b000001));
    chk("timeout", "rsp_err", 64'(rspErr), 64'(1));
    chk("timeout", "rsp_rdata", rspRdata, 64'h0);
    chk("timeout", "slv_req", 64'(slvReq), 64'(0));
    te = mkExp(0, 0, 0, 0, 0, 10, 32'h4000_0000, 0, 0, 0);
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 0, 0, 0), te, "to_idle");
    stepAndCheck(mkIn(0, 0, 0, 0, 0, 1, 64'hABCD, 0), te, "to_late");
`endif

    ti = mkIn(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(ti);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
